// File: rtl/magma_pkg.sv
// Magma (GOST R 34.12-2015) shared definitions: FSM states, S-boxes,
// rotation amount, key word count and round-key index helper.
package magma_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUND  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    localparam int KEY_WORDS = 8;
    localparam int ROT       = 11;

    // id-tc26-Z S-boxes. Row n substitutes nibble [31-4n -: 4], so row 0
    // (the standard's pi7) works on the top nibble.
    localparam logic [3:0] SBOX [8][16] = '{
        '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3,
          4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2},
        '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC,
          4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
        '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA,
          4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
        '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD,
          4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
        '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6,
          4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
        '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD,
          4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
        '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC,
          4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
        '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9,
          4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1}
    };

    // Round r -> key word. Reversed order is 7 - (r mod 8), i.e. ~r[2:0].
    function automatic logic [2:0] key_index(
        input int   r,
        input logic decrypt,
        input int   rounds
    );
        logic [2:0] lo;
        logic       fwd;
        lo  = r[2:0];
        fwd = decrypt ? (r < 8) : (r < rounds - 8);
        return fwd ? lo : ~lo;
    endfunction

endpackage

// File: rtl/magma_round_ctrl_if.sv
// Block stream interface of the Magma engine: input block handshake
// (valid/ready/decrypt/data) and output block handshake (valid/ready/data).
interface magma_round_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic        in_decrypt;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    modport master (
        output in_valid, in_decrypt, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_decrypt, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/magma_round.sv
// Combinational Magma round: G = rotl11(S(a0 + key)), then Feistel swap,
// or no swap on the last round. Ports: i_a1/i_a0/i_key/i_last -> o_a1/o_a0.
module magma_round
    import magma_pkg::*;
(
    input  logic [31:0] i_a1,
    input  logic [31:0] i_a0,
    input  logic [31:0] i_key,
    input  logic        i_last,
    output logic [31:0] o_a1,
    output logic [31:0] o_a0
);

    logic [31:0] w_sum;
    logic [31:0] w_sub;
    logic [31:0] w_g;
    logic [31:0] w_mix;

    assign w_sum = i_a0 + i_key;

    always_comb begin
        w_sub = '0;
        for (int n = 0; n < 8; n++) begin
            w_sub[31-4*n -: 4] = SBOX[n][w_sum[31-4*n -: 4]];
        end
    end

    assign w_g   = {w_sub[31-ROT:0], w_sub[31:32-ROT]};
    assign w_mix = i_a1 ^ w_g;

    assign o_a1 = i_last ? w_mix : i_a0;
    assign o_a0 = i_last ? i_a0  : w_mix;

endmodule

// File: rtl/magma_round_ctrl.sv
// Iterative Magma controller: key storage, round counter, IDLE/ROUND/OUTPUT
// FSM. Ports: clk, rst_n, key_we/addr/wdata, key_loaded, busy, bus (slave).
module magma_round_ctrl
    import magma_pkg::*;
#(
    parameter int ROUNDS = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_we,
    input  logic [2:0]          key_addr,
    input  logic [31:0]         key_wdata,
    output logic                key_loaded,
    output logic                busy,
    magma_round_ctrl_if.slave   bus
);

    localparam int CW = $clog2(ROUNDS);
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    state_t                       r_state;
    state_t                       w_next;
    logic [KEY_WORDS-1:0][31:0]   r_key;
    logic [KEY_WORDS-1:0]         r_mask;
    logic [CW-1:0]                r_round;
    logic [31:0]                  r_a1;
    logic [31:0]                  r_a0;
    logic                         r_dec;

    logic [2:0]                   w_kidx;
    logic [31:0]                  w_rkey;
    logic                         w_last;
    logic                         w_accept;
    logic [31:0]                  w_a1n;
    logic [31:0]                  w_a0n;

    assign key_loaded = &r_mask;
    assign w_kidx     = key_index(int'(r_round), r_dec, ROUNDS);
    assign w_rkey     = r_key[w_kidx];
    assign w_last     = (r_round == LAST);
    assign w_accept   = (r_state == IDLE) && bus.in_valid && key_loaded;

    magma_round u_round (
        .i_a1   (r_a1),
        .i_a0   (r_a0),
        .i_key  (w_rkey),
        .i_last (w_last),
        .o_a1   (w_a1n),
        .o_a0   (w_a0n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = ROUND;
            ROUND:   if (w_last) w_next = OUTPUT;
            OUTPUT:  if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        unique case (r_state)
            IDLE:    bus.in_ready = key_loaded;
            ROUND:   busy = 1'b1;
            OUTPUT: begin
                bus.out_valid = 1'b1;
                busy          = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    assign bus.out_data = {r_a1, r_a0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key   <= '0;
            r_mask  <= '0;
            r_round <= '0;
            r_a1    <= '0;
            r_a0    <= '0;
            r_dec   <= 1'b0;
        end else begin
            if (r_state == IDLE && key_we) begin
                r_key[key_addr]  <= key_wdata;
                r_mask[key_addr] <= 1'b1;
            end
            if (w_accept) begin
                r_a1    <= bus.in_data[63:32];
                r_a0    <= bus.in_data[31:0];
                r_dec   <= bus.in_decrypt;
                r_round <= '0;
            end else if (r_state == ROUND) begin
                r_a1    <= w_a1n;
                r_a0    <= w_a0n;
                r_round <= w_last ? '0 : r_round + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_magma_round_ctrl.sv
// Randomized scoreboard bench for magma_round_ctrl with a loop-based
// Magma reference model, directed key/backpressure/reset scenarios.
module tb_magma_round_ctrl;

    localparam int ROUNDS = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_we;
    logic [2:0]  key_addr;
    logic [31:0] key_wdata;
    logic        key_loaded;
    logic        busy;

    magma_round_ctrl_if bus ();

    magma_round_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_we     (key_we),
        .key_addr   (key_addr),
        .key_wdata  (key_wdata),
        .key_loaded (key_loaded),
        .busy       (busy),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    // Standard S-boxes pi0..pi7; pi_n substitutes nibble n counted from LSB.
    int PI [8][16] = '{
        '{12,4,6,2,10,5,11,9,14,8,13,7,0,3,15,1},
        '{6,8,2,3,9,10,5,12,1,14,4,7,11,13,0,15},
        '{11,3,5,8,2,15,10,13,14,1,7,4,12,9,6,0},
        '{12,8,2,1,13,4,15,6,7,0,10,5,3,14,9,11},
        '{7,15,5,10,8,1,6,13,0,9,3,14,11,4,2,12},
        '{5,13,15,6,9,2,12,10,11,7,8,1,4,3,14,0},
        '{8,14,2,5,6,9,1,12,15,4,11,0,13,10,3,7},
        '{1,7,14,13,0,5,8,3,4,15,10,6,9,12,11,2}
    };

    logic [31:0] KV [8] = '{
        32'hffeeddcc, 32'hbbaa9988, 32'h77665544, 32'h33221100,
        32'hf0f1f2f3, 32'hf4f5f6f7, 32'hf8f9fafb, 32'hfcfdfeff
    };
    localparam logic [63:0] PT = 64'hfedcba9876543210;
    localparam logic [63:0] CT = 64'h4ee901e5c2d8ca3d;

    logic [31:0] kmod [8];
    logic [63:0] sb [$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit prev_ov = 1'b0;

    function automatic logic [31:0] g_fn(input logic [31:0] x, input logic [31:0] k);
        logic [31:0] t;
        logic [31:0] s;
        t = x + k;
        s = 0;
        for (int n = 0; n < 8; n++) begin
            s = s | (32'(PI[n][(t >> (4 * n)) & 32'hf]) << (4 * n));
        end
        return (s << 11) | (s >> 21);
    endfunction

    function automatic logic [63:0] magma_ref(input logic [63:0] blk, input bit dec);
        int          enc [ROUNDS];
        int          ks [ROUNDS];
        logic [31:0] a1;
        logic [31:0] a0;
        logic [31:0] t;
        for (int i = 0; i < ROUNDS; i++) begin
            enc[i] = (i < ROUNDS - 8) ? (i % 8) : (7 - i % 8);
        end
        for (int i = 0; i < ROUNDS; i++) begin
            ks[i] = dec ? enc[ROUNDS - 1 - i] : enc[i];
        end
        a1 = blk[63:32];
        a0 = blk[31:0];
        for (int i = 0; i < ROUNDS; i++) begin
            t = a1 ^ g_fn(a0, kmod[ks[i]]);
            if (i < ROUNDS - 1) begin
                a1 = a0;
                a0 = t;
            end else begin
                a1 = t;
            end
        end
        return {a1, a0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) acc_cyc = cyc + 1;
        cyc = cyc + 1;
    end

    // Monitor: latency on out_valid rise, data on each output handshake.
    always @(negedge clk) begin
        if (bus.out_valid && !prev_ov) begin
            n_cmp++;
            if (cyc - acc_cyc != ROUNDS) begin
                n_bad++;
                $display("FAIL latency: got %0d want %0d", cyc - acc_cyc, ROUNDS);
            end
        end
        prev_ov = bus.out_valid;
        if (bus.out_valid && bus.out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL out_data: got %h want none", bus.out_data);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                if (bus.out_data !== e) begin
                    n_bad++;
                    $display("FAIL out_data: got %h want %h", bus.out_data, e);
                end
            end
        end
    end

    task automatic wr_key(input int a, input logic [31:0] d, input bit taken);
        key_we    = 1'b1;
        key_addr  = 3'(a);
        key_wdata = d;
        @(posedge clk);
        #1;
        key_we = 1'b0;
        if (taken) kmod[a] = d;
    endtask

    task automatic load_key(input bit rnd);
        for (int a = 0; a < 8; a++) wr_key(a, rnd ? $urandom : KV[a], 1'b1);
    endtask

    task automatic send(input logic [63:0] d, input bit dec, input logic [63:0] exp);
        int i;
        for (i = 0; i < 50 && !bus.in_ready; i++) begin
            @(posedge clk);
            #1;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
            return;
        end
        sb.push_back(exp);
        bus.in_valid   = 1'b1;
        bus.in_data    = d;
        bus.in_decrypt = dec;
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        bus.in_data    = {$urandom, $urandom};
        bus.in_decrypt = 1'($urandom);
    endtask

    task automatic drain(input int delay, input logic [63:0] exp);
        int i;
        for (i = 0; i < ROUNDS + 5 && !bus.out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        if (!bus.out_valid) begin
            chk("out_valid_timeout", 64'(bus.out_valid), 64'd1);
            return;
        end
        for (int j = 0; j < delay; j++) begin
            chk("bp_data", bus.out_data, exp);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("post_in_ready", 64'(bus.in_ready), 64'd1);
        chk("post_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        bit          dec;
        logic [63:0] e;
        rst_n          = 1'b0;
        key_we         = 1'b0;
        key_addr       = '0;
        key_wdata      = '0;
        bus.in_valid   = 1'b0;
        bus.in_decrypt = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        for (int a = 0; a < 8; a++) kmod[a] = '0;
        #12;
        chk("rst_key_loaded", 64'(key_loaded), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Partial key load with a block waiting: nothing may be accepted.
        bus.in_valid = 1'b1;
        bus.in_data  = PT;
        for (int a = 0; a < 7; a++) wr_key(a, KV[a], 1'b1);
        chk("part_key_loaded", 64'(key_loaded), 64'd0);
        chk("part_in_ready", 64'(bus.in_ready), 64'd0);
        chk("part_busy", 64'(busy), 64'd0);
        bus.in_valid = 1'b0;
        wr_key(7, KV[7], 1'b1);
        chk("full_in_ready", 64'(bus.in_ready), 64'd1);
        chk("full_key_loaded", 64'(key_loaded), 64'd1);
        chk("full_busy", 64'(busy), 64'd0);

        send(PT, 1'b0, CT);
        drain(0, CT);
        send(CT, 1'b1, PT);
        drain(0, PT);

        send(PT, 1'b0, CT);
        drain(10, CT);

        // Key write during round 10 must be ignored.
        send(PT, 1'b0, CT);
        repeat (10) @(posedge clk);
        #1;
        wr_key(3, 32'h0, 1'b0);
        drain(0, CT);
        send(PT, 1'b0, CT);
        drain(0, CT);

        // Random keys and blocks against the reference model.
        for (int k = 0; k < 3; k++) begin
            load_key(1'b1);
            for (int t = 0; t < 5; t++) begin
                d   = {$urandom, $urandom};
                dec = 1'($urandom);
                e   = magma_ref(d, dec);
                send(d, dec, e);
                drain(int'($urandom_range(0, 3)), e);
            end
        end

        // Reset during round 15: clears state without a clock edge.
        load_key(1'b0);
        send(PT, 1'b0, CT);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_key_loaded", 64'(key_loaded), 64'd0);
        sb.delete();
        for (int a = 0; a < 8; a++) kmod[a] = '0;
        #3;
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1;
            chk("mrst_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        load_key(1'b0);
        chk("reload_in_ready", 64'(bus.in_ready), 64'd1);
        send(PT, 1'b0, CT);
        drain(2, CT);

        repeat (3) @(posedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/magma_round_ctrl.md
Name: magma_round_ctrl

Overview:
Iterative GOST R 34.12-2015 "Magma" (64-bit block, 256-bit key) encrypt/decrypt engine controller.
- Owns the key registers and the round counter.
- Derives the per-round key index for encrypt or decrypt order.
- Sequences one Magma round per clock through a single round-function datapath.
- Sits between a block producer and consumer, with valid/ready handshakes on both sides.

Parameters:
ROUNDS, 32, number of Feistel rounds; must be a multiple of 8 and >= 16 (32 for standard Magma; smaller values are for debug only).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
key_we  input  1  key word write strobe
key_addr  input  3  key word index; 0 = most significant 32 bits of the 256-bit key
key_wdata  input  32  key word data
key_loaded  output  1  all 8 key words written since reset
in_valid  input  1  input block valid
in_ready  output  1  controller can accept a block
in_decrypt  input  1  0 = encrypt, 1 = decrypt; sampled with the block
in_data  input  64  input block; [63:32] = a1, [31:0] = a0
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  64  result block, same packing as in_data
busy  output  1  high in ROUND or OUTPUT state

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all key regs=0, written mask=0, key_loaded=0, round counter=0, out_valid=0, out_data=0, in_ready=0, busy=0. Applies immediately, including mid-round; any in-flight block is discarded.
- Key load:
  - key_we in IDLE writes K[key_addr] and sets mask[key_addr].
  - key_loaded = &mask. Rewriting a word is allowed and key_loaded stays 1.
  - key_we in ROUND/OUTPUT is ignored, with no state change.
- States:
  - IDLE: in_ready = key_loaded.
    - On in_valid && in_ready: latch a1, a0, mode; set r=0; go to ROUND.
  - ROUND: one round per cycle, r = 0..ROUNDS-1.
    - Round function: G = rotl11(S(a0 + Kidx mod 2^32)).
    - S applies 8 4-bit S-boxes; S-box 0 acts on nibble [31:28], S-box 7 on [3:0].
    - For r < ROUNDS-1: (a1, a0) <= (a0, a1 ^ G).
    - For r = ROUNDS-1 (no swap): (a1, a0) <= (a1 ^ G, a0), then go to OUTPUT.
  - OUTPUT: out_valid=1 and out_data={a1,a0}, both held stable until out_ready.
    - On out_valid && out_ready: out_valid=0 next cycle, go to IDLE.
- Key index:
  - Encrypt: r < ROUNDS-8 gives r mod 8; otherwise 7 - (r mod 8).
  - Decrypt: r < 8 gives r; otherwise 7 - (r mod 8).
  - For ROUNDS=32 this is encrypt K0..7 three times then K7..0, and decrypt K0..7 then K7..0 three times.
- Latency: out_valid rises ROUNDS cycles after the accepting edge (32 for default).
- Throughput: in_ready is low from the accept edge until the cycle after the output handshake, so the minimum period is ROUNDS+2 cycles. There is no overlap of input and output.
- in_data and in_decrypt are don't-care when not accepted. in_valid while key_loaded=0 is not accepted and not remembered.
- Arithmetic: the key addition wraps modulo 2^32; no carry out.
- busy = (state != IDLE).

Decomposition:
- Package magma_pkg:
  - state enum {IDLE, ROUND, OUTPUT}
  - constant S-box table, 8x16x4 (id-tc26-Z set)
  - rotation constant 11
  - key-word count 8
  - function key_index(r, decrypt, ROUNDS)
- Sub-module magma_round (combinational): inputs a1, a0, round key, last; outputs next a1, a0.
- The controller holds all registers, the FSM and the key storage.

Test Plan:
- Full key load:
  - Load key ffeeddcc bbaa9988 77665544 33221100 f0f1f2f3 f4f5f6f7 f8f9fafb fcfdfeff at addr 0..7.
  - Encrypt fedcba9876543210.
  - Expect out_data=4ee901e5c2d8ca3d, with out_valid exactly 32 cycles after the accept edge.
- Decrypt: same key, decrypt 4ee901e5c2d8ca3d -> expect out_data=fedcba9876543210.
- Partial key load: write addr 0..6 only with in_valid=1 -> key_loaded=0, in_ready=0, no accept. Write addr 7 -> in_ready=1 next cycle.
- Output backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, busy=1. Raise out_ready -> IDLE next cycle, in_ready=1.
- Key write mid-operation: key_we with addr 3, data 0 during round 10 -> ignored; result still 4ee901e5c2d8ca3d. A following encrypt also gives 4ee901e5c2d8ca3d.
- Reset mid-operation: pulse rst_n low during round 15 -> out_valid=0, busy=0, key_loaded=0 without waiting for clk. After release, in_ready stays 0 until the key is reloaded.
